// File: rtl/dma_cmd_sequencer_if.sv
// Bundle of the command handshake, DMA register-write port and status pulses of the sequencer.
// master drives commands, acks and eop; slave is the sequencer itself.
interface dma_cmd_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_src;
  logic [15:0] cmd_dst;
  logic [15:0] cmd_count;
  logic        reg_wr;
  logic        reg_ack;
  logic [15:0] Address_bus;
  logic [15:0] data_bus;
  logic        dma_eop;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output cmd_valid, cmd_src, cmd_dst, cmd_count, reg_ack, dma_eop,
    input  cmd_ready, reg_wr, Address_bus, data_bus, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_src, cmd_dst, cmd_count, reg_ack, dma_eop,
    output cmd_ready, reg_wr, Address_bus, data_bus, busy, done, err
  );
endinterface

// File: rtl/dma_cmd_sequencer.sv
// Turns one transfer command into a six-write DMA register program, then waits for end-of-process
// with a timeout that triggers an abort write. Writes hold until acked; done/err are one-cycle pulses.
module dma_cmd_sequencer #(
  parameter int MEM_LIMIT = 32764,
  parameter int TIMEOUT   = 1000
) (
  input  logic                clk,
  input  logic                rst,
  dma_cmd_sequencer_if.slave  bus
);
  localparam logic [15:0] MEM_LIM  = 16'(MEM_LIMIT);
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WRITE, WAIT_EOP, ABORT} state_t;
  typedef enum logic [1:0] {K_M2M, K_M2IO, K_IO2M} kind_t;

  state_t      state, state_nxt;
  kind_t       kind, kind_nxt;
  logic [2:0]  idx, idx_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [15:0] src_q, dst_q, count_q;
  logic        done_q, err_q, done_nxt, err_nxt;
  logic        accept, src_mem, dst_mem;
  logic [15:0] wr_addr, wr_data;

  assign accept  = bus.cmd_valid && (state == IDLE);
  assign src_mem = (bus.cmd_src <= MEM_LIM);
  assign dst_mem = (bus.cmd_dst <= MEM_LIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      kind    <= K_M2M;
      idx     <= '0;
      cnt     <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      kind   <= kind_nxt;
      idx    <= idx_nxt;
      cnt    <= cnt_nxt;
      done_q <= done_nxt;
      err_q  <= err_nxt;
      if (accept) begin
        src_q   <= bus.cmd_src;
        dst_q   <= bus.cmd_dst;
        count_q <= bus.cmd_count;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    kind_nxt  = kind;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!src_mem && !dst_mem) begin
            err_nxt = 1'b1;
          end else begin
            state_nxt = WRITE;
            idx_nxt   = '0;
            kind_nxt  = src_mem ? (dst_mem ? K_M2M : K_M2IO) : K_IO2M;
          end
        end
      end
      WRITE: begin
        if (bus.reg_ack) begin
          if (idx == 3'd5) begin
            state_nxt = WAIT_EOP;
            idx_nxt   = '0;
            cnt_nxt   = '0;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end
      end
      WAIT_EOP: begin
        // eop takes priority over a simultaneous timeout
        if (bus.dma_eop) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ABORT;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      ABORT: begin
        if (bus.reg_ack) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Register program for the current index; zero whenever no write is pending.
  always_comb begin
    wr_addr = '0;
    wr_data = '0;
    if (state == ABORT) begin
      wr_addr = 16'd11;
      wr_data = 16'h0001;
    end else if (state == WRITE) begin
      case (idx)
        3'd0: begin
          wr_addr = 16'd1;
          wr_data = count_q;
        end
        3'd1: begin
          wr_addr = 16'd0;
          wr_data = (kind == K_IO2M) ? dst_q : src_q;
        end
        3'd2: begin
          wr_addr = (kind == K_M2M) ? 16'd13 : 16'd10;
          wr_data = (kind == K_M2M) ? dst_q : ((kind == K_M2IO) ? 16'h0004 : 16'h0008);
        end
        3'd3: begin
          wr_addr = 16'd7;
          wr_data = (kind == K_M2M) ? 16'h0001 : ((kind == K_M2IO) ? 16'h0000 : 16'h0080);
        end
        3'd4: wr_addr = 16'd11;
        3'd5: wr_addr = 16'd12;
        default: begin
          wr_addr = '0;
          wr_data = '0;
        end
      endcase
    end
  end

  assign bus.cmd_ready   = (state == IDLE);
  assign bus.reg_wr      = (state == WRITE) || (state == ABORT);
  assign bus.Address_bus = wr_addr;
  assign bus.data_bus    = wr_data;
  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_dma_cmd_sequencer.sv
// Randomized bench for dma_cmd_sequencer against a transaction-level model of the write program,
// eop/timeout outcome and status pulses; inputs change and outputs are sampled on the falling edge.
module tb_dma_cmd_sequencer;
  localparam int TMO  = 4;
  localparam int MEML = 32764;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dma_cmd_sequencer_if bus();

  dma_cmd_sequencer #(.MEM_LIMIT(MEML), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_bad = 0;
  logic [15:0] ea [6];
  logic [15:0] ev [6];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // 0 = M2M, 1 = M2IO, 2 = IO2M, 3 = reject
  function automatic int classify(input logic [15:0] s, input logic [15:0] d);
    bit sm, dm;
    sm = (int'(s) <= MEML);
    dm = (int'(d) <= MEML);
    if (sm && dm) return 0;
    if (sm)       return 1;
    if (dm)       return 2;
    return 3;
  endfunction

  task automatic set_expect(input int k, input logic [15:0] s, input logic [15:0] d, input logic [15:0] c);
    case (k)
      0: begin
        ea = '{16'd1, 16'd0, 16'd13, 16'd7, 16'd11, 16'd12};
        ev = '{c, s, d, 16'h0001, 16'h0000, 16'h0000};
      end
      1: begin
        ea = '{16'd1, 16'd0, 16'd10, 16'd7, 16'd11, 16'd12};
        ev = '{c, s, 16'h0004, 16'h0000, 16'h0000, 16'h0000};
      end
      default: begin
        ea = '{16'd1, 16'd0, 16'd10, 16'd7, 16'd11, 16'd12};
        ev = '{c, d, 16'h0008, 16'h0080, 16'h0000, 16'h0000};
      end
    endcase
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_wr"},   32'(bus.reg_wr), 0);
    check({tag, "_addr"}, 32'(bus.Address_bus), 0);
    check({tag, "_data"}, 32'(bus.data_bus), 0);
  endtask

  // Called on a falling edge: idle cycles with random ack/eop noise that must be ignored.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.reg_ack = 1'($urandom_range(1, 0));
      bus.dma_eop = 1'($urandom_range(1, 0));
      @(negedge clk);
      check_quiet("idle");
      check("idle_busy",  32'(bus.busy), 0);
      check("idle_ready", 32'(bus.cmd_ready), 1);
      check("idle_done",  32'(bus.done), 0);
      check("idle_err",   32'(bus.err), 0);
    end
    bus.reg_ack = 1'b0;
    bus.dma_eop = 1'b0;
  endtask

  // Called on a falling edge with the sequencer idle; returns on the falling edge where done/err shows.
  // eop_at >= TMO means eop never comes and the transfer times out.
  task automatic run_cmd(input logic [15:0] s, input logic [15:0] d, input logic [15:0] c,
                         input int ack_min, input int ack_max, input int eop_at);
    int k, wait_n, w;
    k = classify(s, d);
    check("ready_before_cmd", 32'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_src   = s;
    bus.cmd_dst   = d;
    bus.cmd_count = c;
    bus.reg_ack   = 1'b0;
    bus.dma_eop   = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_src   = 16'($urandom);
    bus.cmd_dst   = 16'($urandom);
    bus.cmd_count = 16'($urandom);
    if (k == 3) begin
      check("rej_err",   32'(bus.err), 1);
      check("rej_done",  32'(bus.done), 0);
      check("rej_ready", 32'(bus.cmd_ready), 1);
      check("rej_busy",  32'(bus.busy), 0);
      check_quiet("rej");
      @(negedge clk);
      check("rej_err_pulse", 32'(bus.err), 0);
      check_quiet("rej2");
      return;
    end
    set_expect(k, s, d, c);
    for (int i = 0; i < 6; i++) begin
      wait_n = int'($urandom_range(ack_max, ack_min));
      for (int j = 0; j <= wait_n; j++) begin
        check($sformatf("wr%0d_req", i),  32'(bus.reg_wr), 1);
        check($sformatf("wr%0d_addr", i), 32'(bus.Address_bus), 32'(ea[i]));
        check($sformatf("wr%0d_data", i), 32'(bus.data_bus), 32'(ev[i]));
        check("wr_busy",  32'(bus.busy), 1);
        check("wr_ready", 32'(bus.cmd_ready), 0);
        check("wr_done",  32'(bus.done), 0);
        check("wr_err",   32'(bus.err), 0);
        bus.reg_ack = (j == wait_n);
        bus.dma_eop = 1'($urandom_range(1, 0));
        @(negedge clk);
      end
    end
    for (w = 0; w < TMO; w++) begin
      check_quiet("weop");
      check("weop_busy", 32'(bus.busy), 1);
      check("weop_done", 32'(bus.done), 0);
      check("weop_err",  32'(bus.err), 0);
      bus.dma_eop = (w == eop_at);
      bus.reg_ack = 1'($urandom_range(1, 0));
      @(negedge clk);
      if (w == eop_at) break;
    end
    bus.dma_eop = 1'b0;
    bus.reg_ack = 1'b0;
    if (eop_at < TMO) begin
      check("eop_done",  32'(bus.done), 1);
      check("eop_err",   32'(bus.err), 0);
      check("eop_busy",  32'(bus.busy), 0);
      check("eop_ready", 32'(bus.cmd_ready), 1);
      check_quiet("eop");
    end else begin
      wait_n = int'($urandom_range(ack_max, ack_min));
      for (int j = 0; j <= wait_n; j++) begin
        check("abort_req",  32'(bus.reg_wr), 1);
        check("abort_addr", 32'(bus.Address_bus), 11);
        check("abort_data", 32'(bus.data_bus), 1);
        check("abort_busy", 32'(bus.busy), 1);
        check("abort_done", 32'(bus.done), 0);
        check("abort_err",  32'(bus.err), 0);
        bus.reg_ack = (j == wait_n);
        bus.dma_eop = 1'($urandom_range(1, 0));
        @(negedge clk);
      end
      bus.reg_ack = 1'b0;
      bus.dma_eop = 1'b0;
      check("tmo_err",   32'(bus.err), 1);
      check("tmo_done",  32'(bus.done), 0);
      check("tmo_busy",  32'(bus.busy), 0);
      check("tmo_ready", 32'(bus.cmd_ready), 1);
      check_quiet("tmo");
    end
  endtask

  task automatic reset_mid_sequence();
    bus.cmd_valid = 1'b1;
    bus.cmd_src   = 16'h0300;
    bus.cmd_dst   = 16'h0400;
    bus.cmd_count = 16'd9;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.reg_ack   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.reg_ack = 1'b0;
    @(negedge clk);
    check("mid_idx2_addr", 32'(bus.Address_bus), 13);
    check("mid_idx2_data", 32'(bus.data_bus), 32'h0400);
    #2 rst = 1'b1;
    #1;
    check_quiet("rst_now");
    check("rst_now_busy",  32'(bus.busy), 0);
    check("rst_now_ready", 32'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b1;
    bus.reg_ack   = 1'b1;
    @(negedge clk);
    check("rst_noaccept_busy", 32'(bus.busy), 0);
    check("rst_noaccept_done", 32'(bus.done), 0);
    check("rst_noaccept_err",  32'(bus.err), 0);
    check_quiet("rst_hold");
    bus.cmd_valid = 1'b0;
    bus.reg_ack   = 1'b0;
    rst = 1'b0;
    idle(3);
  endtask

  logic [15:0] rs, rd;
  int pick;

  initial begin
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_src   = '0;
    bus.cmd_dst   = '0;
    bus.cmd_count = '0;
    bus.reg_ack   = 1'b0;
    bus.dma_eop   = 1'b0;
    #1;
    check_quiet("reset");
    check("reset_busy",  32'(bus.busy), 0);
    check("reset_done",  32'(bus.done), 0);
    check("reset_err",   32'(bus.err), 0);
    check("reset_ready", 32'(bus.cmd_ready), 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_cmd(16'h0100, 16'h0200, 16'd16, 0, 0, 2);
    idle(2);
    run_cmd(16'h9000, 16'h0040, 16'd16, 2, 2, 1);
    idle(1);
    run_cmd(16'h9000, 16'h9000, 16'd5, 0, 0, 0);
    run_cmd(16'h0100, 16'h9000, 16'd8, 0, 1, TMO);
    run_cmd(16'd32764, 16'd32765, 16'd3, 0, 1, TMO - 1);
    run_cmd(16'd32765, 16'h0040, 16'd4, 0, 1, 0);
    run_cmd(16'd32765, 16'd32765, 16'd4, 0, 0, 0);
    idle(1);
    reset_mid_sequence();
    run_cmd(16'h0300, 16'h0400, 16'd9, 0, 0, 1);

    for (int n = 0; n < 40; n++) begin
      pick = int'($urandom_range(3, 0));
      rs = (pick == 0) ? 16'(MEML + int'($urandom_range(2, 0)) - 1) : 16'($urandom);
      rd = (pick == 1) ? 16'(MEML + int'($urandom_range(2, 0)) - 1) : 16'($urandom);
      run_cmd(rs, rd, 16'($urandom), 0, int'($urandom_range(3, 0)), int'($urandom_range(TMO, 0)));
      idle(int'($urandom_range(2, 0)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
